cpu_step_ctrl: RTL



---
 rtl/cpu_step_pkg.sv | 27 ++
 rtl/btn_debounce.sv | 41 ++++
 rtl/cpu_step_ctrl.sv | 93 +++++++++
 3 files changed

// File: rtl/cpu_step_pkg.sv
// Shared types for the CPU step controller: state encoding and run-mode constants.
package cpu_step_pkg;

  typedef enum logic [2:0] {
    ST_HALT  = 3'd0,
    ST_RUN   = 3'd1,
    ST_STEP  = 3'd2,
    ST_BURST = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  localparam logic [1:0] MODE_HALT  = 2'b00;
  localparam logic [1:0] MODE_RUN   = 2'b01;
  localparam logic [1:0] MODE_STEP  = 2'b10;
  localparam logic [1:0] MODE_BURST = 2'b11;

  // State requested by the mode pins; DONE is never requested directly.
  function automatic state_t mode_to_state(input logic [1:0] mode);
    case (mode)
      MODE_RUN:   return ST_RUN;
      MODE_STEP:  return ST_STEP;
      MODE_BURST: return ST_BURST;
      default:    return ST_HALT;
    endcase
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Two-flop synchroniser plus debouncer for a raw push-button.
// level changes only after DEB_CYCLES consecutive samples that differ from it; rise pulses with a 0->1 change.
module btn_debounce #(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int            CW       = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic [1:0]    sync;
  logic [CW-1:0] cnt;

  // NOTE: every flop here uses <= so all of them sample the pre-edge values, which is what makes the synchroniser a real two-stage chain.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync  <= '0;
      cnt   <= '0;
      level <= 1'b0;
      rise  <= 1'b0;
    end else begin
      sync <= {sync[0], btn};
      rise <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        cnt   <= '0;
        level <= sync[1];
        rise  <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Clock-enable generator for a multicycle core: HALT / RUN / single STEP / counted BURST.
// Define CPU_STEP_CYCLE_CNT_EN to build the cpu_en pulse counter on cycle_cnt; otherwise it reads 0.
module cpu_step_ctrl
  import cpu_step_pkg::*;
#(
  parameter int DIV_W      = 26,
  parameter int DEB_CYCLES = 500000,
  parameter int BURST_W    = 16,
  parameter int CNT_W      = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         mode,
  input  logic [DIV_W-1:0]   div_val,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               step_btn,
  output logic               cpu_en,
  output logic               tick_led,
  output logic [2:0]         state_o,
  output logic               burst_done,
  output logic [CNT_W-1:0]   cycle_cnt
);

  state_t             state, state_nxt;
  logic [DIV_W-1:0]   div_cnt, div_cnt_nxt;
  logic [BURST_W-1:0] remain, remain_nxt;
  logic               held, counting, fire;
  logic               btn_rise;
  logic               btn_level_unused;

  // Only the edge matters to STEP; the debounced level is left for a future indicator.
  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk   (clk),
    .reset (reset),
    .btn   (step_btn),
    .level (btn_level_unused),
    .rise  (btn_rise)
  );

  // A mode change always wins over a terminal count or a step edge in the same cycle.
  assign held     = (state == mode_to_state(mode)) || (state == ST_DONE && mode == MODE_BURST);
  assign counting = (state == ST_RUN) || (state == ST_BURST);
  assign fire     = held && ((counting && div_cnt == div_val) || (state == ST_STEP && btn_rise));

  // NOTE: defaults are assigned before any branch so no path leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_nxt   = state;
    remain_nxt  = remain;
    div_cnt_nxt = '0;
    if (!held) begin
      state_nxt = mode_to_state(mode);
      if (state_nxt == ST_BURST) begin
        remain_nxt = burst_len;
        if (burst_len == '0) state_nxt = ST_DONE;
      end
    end else if (fire && state == ST_BURST) begin
      remain_nxt = remain - 1'b1;
      if (remain == BURST_W'(1)) state_nxt = ST_DONE;
    end
    // Free-running increment also covers a div_val lowered below the count: it wraps through all-ones.
    if (held && counting && !fire) div_cnt_nxt = div_cnt + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_HALT;
      div_cnt    <= '0;
      remain     <= '0;
      cpu_en     <= 1'b0;
      tick_led   <= 1'b0;
      burst_done <= 1'b0;
    end else begin
      state      <= state_nxt;
      div_cnt    <= div_cnt_nxt;
      remain     <= remain_nxt;
      cpu_en     <= fire;
      tick_led   <= tick_led ^ cpu_en;
      burst_done <= (state_nxt == ST_DONE);
    end
  end

  assign state_o = state;

`ifdef CPU_STEP_CYCLE_CNT_EN
  always_ff @(posedge clk) begin
    if (!reset)    cycle_cnt <= '0;
    else if (fire) cycle_cnt <= cycle_cnt + 1'b1;
  end
`else
  assign cycle_cnt = '0;
`endif

endmodule
